series_sum_seq: RTL
===================

# series_sum_seq

Sequential, parametrised series-sum engine: computes the sum of the first N terms of a selected integer series, adding one term per clock under a start/done handshake. It generalises the combinational 1..N summation block to wider operands, four series modes, an overflow flag and a held result. It sits beside the other behavioural arithmetic blocks as a multi-cycle datapath unit that other controllers drive.

## Interface
Parameters:
- NW, 8: width of the term count N.
- SW, 24: width of the accumulator and result.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request a computation; sampled only in IDLE.
- n  in  NW  number of terms; captured when start is accepted.
- mode  in  2  series select: 00 = i, 01 = i², 10 = 2i−1 (odd), 11 = 2i (even). Captured with n.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result is valid from this cycle onward.
- result  out  SW  final sum modulo 2^SW; held until the next accepted start.
- ovf  out  1  high if the true sum exceeded 2^SW−1; held with result.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - On start=1: capture n→n_q and mode→m_q, clear acc and ovf, load i=1, then go to RUN.
  - With start=0: remain in IDLE.
- **RUN, i ≤ n_q:** acc ← acc + term(i), then i ← i+1.
  - term(i) is computed at SW width; i² uses a full-width product truncated to SW.
  - Carry out of the SW-bit add sets ovf (sticky); acc wraps.
  - Overflow of term(i) itself beyond SW bits also sets ovf.
- **RUN, i > n_q:** no add; result ← acc; go to DONE.
- **DONE:** done=1 for exactly one cycle, then go to IDLE unconditionally.
- The i counter is NW+1 bits wide, so n = 2^NW−1 terminates without wrap-around.
- n=0: no terms are added; result=0, ovf=0.
- start while busy=1: ignored, with no effect on n_q, m_q, acc or result.
- start asserted in the DONE cycle: ignored. It is accepted from the following IDLE cycle if still high.
- n and mode changing after capture: no effect on the running computation.
- result and ovf keep their last values through RUN and DONE of later operations. They update only at the RUN→DONE edge.

## Timing
- Reset (rst_n=0 at a clock edge) forces:
  - state=IDLE, i=0, acc=0
  - result=0, ovf=0, busy=0, done=0
- Reset mid-operation aborts the operation with no done pulse. It takes priority over start.
- Let edge E be the edge that samples start in IDLE:
  - busy rises after E.
  - Term adds occur at edges E+1 … E+n.
  - result and ovf load at edge E+n+1.
  - done is high during the cycle after edge E+n+1.
  - busy falls after edge E+n+2.
- Latency from start acceptance to done: n+2 cycles (n=0 → 2 cycles).
- Minimum spacing between back-to-back accepted starts: n+3 cycles.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then n=10, mode=00, start for one cycle:
  - done pulses 12 cycles after the sampling edge.
  - result=55, ovf=0.
  - busy is high for 12 cycles.
- n=10 with each remaining mode:
  - mode=01 → 385
  - mode=10 → 100
  - mode=11 → 110
  - ovf=0 in every case.
- n=0, mode=01:
  - done 2 cycles after acceptance, result=0.
- SW=8, NW=8, n=255, mode=00:
  - result = 32640 mod 256 = 128, ovf=1, no counter wrap.
  - done appears after 257 cycles.
- Start held high through an n=3 run, with n changed to 9 mid-run:
  - First result=6.
  - A second operation starts in the IDLE cycle after done, using n=9, giving result=45.
- rst_n=0 during RUN of an n=20 run:
  - All outputs return to 0 on the next edge, with no done pulse.
  - A new n=4 run then completes with result=10.

Source files
------------

// File: rtl/series_sum_seq.sv
// rtl/series_sum_seq.sv - multi-cycle series-sum engine, one term per clock, start/done handshake
module series_sum_seq #(
    parameter int NW = 8,
    parameter int SW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] n,
    input  logic [1:0]    mode,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] result,
    output logic          ovf
);

    // Term width wide enough for i*i and 2i of an NW+1 bit counter, never narrower than SW
    localparam int FW = 2 * (NW + 2);
    localparam int XW = (FW > SW) ? FW : SW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [NW-1:0] n_q;
    logic [1:0]    m_q;
    logic [NW:0]   i_q;
    logic [SW-1:0] acc_q;
    logic          acc_ovf_q;
    logic [SW-1:0] result_q;
    logic          ovf_q;

    logic [XW-1:0] i_x;
    logic [XW-1:0] term_x;
    logic [SW-1:0] term;
    logic          term_ovf;
    logic [SW:0]   sum_d;
    logic          more_d;

    // Current term at full width, its truncation to SW bits and the widened accumulate
    always_comb begin
        i_x    = XW'(i_q);
        term_x = '0;
        case (m_q)
            2'b00:   term_x = i_x;
            2'b01:   term_x = i_x * i_x;
            2'b10:   term_x = (i_x << 1) - XW'(1);
            default: term_x = i_x << 1;
        endcase
        term     = term_x[SW-1:0];
        term_ovf = |(term_x >> SW);
        sum_d    = {1'b0, acc_q} + {1'b0, term};
        more_d   = (i_q <= {1'b0, n_q});
    end

    // Control FSM and datapath: capture operands, accumulate terms, publish result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            m_q       <= '0;
            i_q       <= '0;
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q       <= n;
                        m_q       <= mode;
                        acc_q     <= '0;
                        acc_ovf_q <= 1'b0;
                        i_q       <= (NW+1)'(1);
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (more_d) begin
                        acc_q     <= sum_d[SW-1:0];
                        acc_ovf_q <= acc_ovf_q | sum_d[SW] | term_ovf;
                        i_q       <= i_q + (NW+1)'(1);
                    end else begin
                        result_q  <= acc_q;
                        ovf_q     <= acc_ovf_q;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule
